// File: rtl/axi_rd_timeout_guard.sv
// Read-channel timeout guard: tracks outstanding ARs, drains them with SLVERR
// on a budget overrun and holds the subordinate isolated until cleared.

package axi_rd_timeout_guard_pkg;
  localparam int unsigned IdW   = 2;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [5:0]       atop;
  } aw_chan_t;

  typedef struct packed {
    logic [DataW-1:0]   data;
    logic [DataW/8-1:0] strb;
    logic               last;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
  } ar_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } rsp_t;
endpackage

module axi_rd_timeout_guard #(
  parameter int unsigned AxiIdWidth = 2,
  parameter int unsigned MaxTxns    = 4,
  parameter int unsigned CntWidth   = 16,
  parameter type         req_t      = axi_rd_timeout_guard_pkg::req_t,
  parameter type         rsp_t      = axi_rd_timeout_guard_pkg::rsp_t
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         guard_ena_i,
  input  logic [CntWidth-1:0]          budget_i,
  input  logic                         clr_i,
  input  req_t                         req_i,
  output rsp_t                         rsp_o,
  output req_t                         req_o,
  input  rsp_t                         rsp_i,
  output logic                         irq_o,
  output logic                         rst_req_o,
  output logic [AxiIdWidth-1:0]        fault_id_o,
  output logic [$clog2(MaxTxns+1)-1:0] outstanding_o
);

  localparam int unsigned IdxW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
  localparam int unsigned OutW = $clog2(MaxTxns + 1);

  typedef enum logic [1:0] {StIdle, StDrain, StFault} state_e;

  state_e                state_q, state_d;
  logic [MaxTxns-1:0]    valid_q, valid_d;
  logic [AxiIdWidth-1:0] id_q  [MaxTxns];
  logic [AxiIdWidth-1:0] id_d  [MaxTxns];
  logic [CntWidth-1:0]   cnt_q [MaxTxns];
  logic [CntWidth-1:0]   cnt_d [MaxTxns];
  logic [AxiIdWidth-1:0] fault_id_q, fault_id_d;
  logic [OutW-1:0]       outstanding_q, outstanding_d;

  logic                  full;
  logic                  alloc_found, free_found, serve_found, to_found;
  logic [IdxW-1:0]       alloc_idx, free_idx, serve_idx, to_idx;
  logic [CntWidth-1:0]   free_cnt;
  logic                  ar_hs, free_en;

  // Full comes from registered state only: a free this cycle does not open a slot.
  assign full = &valid_q;

  // Table lookups: lowest free slot, lowest valid slot, oldest entry matching the R id.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    serve_found = 1'b0;
    serve_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    free_cnt    = '0;
    for (int unsigned i = 0; i < MaxTxns; i++) begin
      if (!valid_q[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IdxW'(i);
      end
      if (valid_q[i] && !serve_found) begin
        serve_found = 1'b1;
        serve_idx   = IdxW'(i);
      end
      if (valid_q[i] && (id_q[i] == rsp_i.r.id) && (!free_found || (cnt_q[i] > free_cnt))) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
        free_cnt   = cnt_q[i];
      end
    end
  end

  // Next-state, table update and channel steering.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    id_d       = id_q;
    fault_id_d = fault_id_q;
    req_o      = req_i;
    rsp_o      = rsp_i;
    ar_hs      = 1'b0;
    free_en    = 1'b0;
    to_found   = 1'b0;
    to_idx     = '0;

    for (int unsigned i = 0; i < MaxTxns; i++) begin
      cnt_d[i] = cnt_q[i];
      if (valid_q[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        req_o.ar_valid = req_i.ar_valid & ~full;
        rsp_o.ar_ready = rsp_i.ar_ready & ~full;
        ar_hs   = req_i.ar_valid & rsp_o.ar_ready & alloc_found;
        free_en = rsp_i.r_valid & req_i.r_ready & rsp_i.r.last & free_found;
        // An entry freed this cycle cannot time out: the R last wins the race.
        for (int unsigned i = 0; i < MaxTxns; i++) begin
          if (valid_q[i] && (cnt_q[i] == budget_i) && !(free_en && (free_idx == IdxW'(i)))
              && !to_found) begin
            to_found = 1'b1;
            to_idx   = IdxW'(i);
          end
        end
        if (free_en) valid_d[free_idx] = 1'b0;
        if (ar_hs) begin
          valid_d[alloc_idx] = 1'b1;
          id_d[alloc_idx]    = req_i.ar.id;
          cnt_d[alloc_idx]   = '0;
        end
        if (to_found && guard_ena_i && (budget_i != '0)) begin
          state_d    = StDrain;
          fault_id_d = id_q[to_idx];
        end
      end
      StDrain, StFault: begin
        req_o.ar_valid = 1'b0;
        req_o.aw_valid = 1'b0;
        req_o.r_ready  = 1'b1;
        rsp_o.ar_ready = 1'b0;
        rsp_o.aw_ready = 1'b0;
        rsp_o.r        = '0;
        rsp_o.r_valid  = 1'b0;
        if (state_q == StDrain) begin
          rsp_o.r.id    = id_q[serve_idx];
          rsp_o.r.resp  = 2'b10;
          rsp_o.r.last  = 1'b1;
          rsp_o.r_valid = serve_found;
          if (serve_found && req_i.r_ready) valid_d[serve_idx] = 1'b0;
          if (valid_d == '0) state_d = StFault;
        end else if (clr_i) begin
          state_d    = StIdle;
          fault_id_d = '0;
          valid_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    outstanding_d = '0;
    for (int unsigned i = 0; i < MaxTxns; i++) begin
      outstanding_d = outstanding_d + OutW'(valid_d[i]);
    end
  end

  // State and table registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      valid_q       <= '0;
      id_q          <= '{default: '0};
      cnt_q         <= '{default: '0};
      fault_id_q    <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      id_q          <= id_d;
      cnt_q         <= cnt_d;
      fault_id_q    <= fault_id_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign irq_o         = (state_q != StIdle);
  assign rst_req_o     = (state_q == StFault);
  assign fault_id_o    = fault_id_q;
  assign outstanding_o = outstanding_q;

endmodule

// File: tb/tb_axi_rd_timeout_guard.sv
// Directed bench for axi_rd_timeout_guard with an R-channel scoreboard.

module tb_axi_rd_timeout_guard;
  import axi_rd_timeout_guard_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        guard_ena;
  logic [15:0] budget;
  logic        clr;
  req_t        req_i, req_o;
  rsp_t        rsp_i, rsp_o;
  logic        irq_o, rst_req_o;
  logic [1:0]  fault_id_o;
  logic [2:0]  outstanding_o;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;
  int unsigned t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_rd_timeout_guard #(
    .AxiIdWidth(2),
    .MaxTxns   (4),
    .CntWidth  (16),
    .req_t     (req_t),
    .rsp_t     (rsp_t)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .guard_ena_i  (guard_ena),
    .budget_i     (budget),
    .clr_i        (clr),
    .req_i        (req_i),
    .rsp_o        (rsp_o),
    .req_o        (req_o),
    .rsp_i        (rsp_i),
    .irq_o        (irq_o),
    .rst_req_o    (rst_req_o),
    .fault_id_o   (fault_id_o),
    .outstanding_o(outstanding_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [36:0] beat(input logic [1:0] id, input logic [31:0] d,
                                       input logic [1:0] resp);
    return {id, d, resp, 1'b1};
  endfunction

  // Monitor: every manager-side R handshake must match the next expected beat.
  always @(negedge clk) begin
    if (rst_n && rsp_o.r_valid && req_i.r_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL r_unexpected: got %0h expected none",
                 {rsp_o.r.id, rsp_o.r.data, rsp_o.r.resp, rsp_o.r.last});
      end else begin
        mon_e = exp_q.pop_front();
        chk("r_beat", 64'({rsp_o.r.id, rsp_o.r.data, rsp_o.r.resp, rsp_o.r.last}), 64'(mon_e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) step();
  endtask

  task automatic check_at(input int unsigned t);
    wait_cyc(t);
    @(negedge clk);
  endtask

  task automatic ar_send(input logic [1:0] id);
    int   n;
    logic ok;
    n = 0;
    req_i.ar_valid = 1'b1;
    req_i.ar.id    = id;
    req_i.ar.addr  = 32'h1000_0000 | (32'(id) << 4);
    do begin
      @(negedge clk);
      ok = rsp_o.ar_ready;
      step();
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL ar_send_timeout: got no ar_ready expected ar_ready within 50 cycles");
    end
    req_i.ar_valid = 1'b0;
  endtask

  task automatic r_send(input logic [1:0] id, input logic [31:0] d, input bit fwd);
    rsp_i.r_valid  = 1'b1;
    rsp_i.r.id     = id;
    rsp_i.r.data   = d;
    rsp_i.r.resp   = 2'b00;
    rsp_i.r.last   = 1'b1;
    if (fwd) exp_q.push_back(beat(id, d, 2'b00));
    step();
    rsp_i.r_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int n;
    req_i          = '0;
    rsp_i          = '0;
    rsp_i.ar_ready = 1'b1;
    rsp_i.aw_ready = 1'b1;
    rsp_i.w_ready  = 1'b1;
    req_i.r_ready  = 1'b1;
    rst_n          = 1'b0;
    guard_ena      = 1'b1;
    budget         = 16'd100;
    clr            = 1'b0;

    // Reset state
    step();
    @(negedge clk);
    chk("rst_irq", 64'(irq_o), 64'd0);
    chk("rst_rst_req", 64'(rst_req_o), 64'd0);
    chk("rst_fault_id", 64'(fault_id_o), 64'd0);
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Normal flow, budget 100
    req_i.ar.addr  = 32'h8000_1234;
    req_i.ar.id    = 2'd1;
    req_i.ar_valid = 1'b1;
    @(negedge clk);
    chk("pass_ar_valid", 64'(req_o.ar_valid), 64'd1);
    chk("pass_ar_addr", 64'(req_o.ar.addr), 64'h8000_1234);
    chk("pass_ar_id", 64'(req_o.ar.id), 64'd1);
    step();
    req_i.ar_valid = 1'b0;
    ar_send(2'd2);
    @(negedge clk);
    chk("norm_outstanding2", 64'(outstanding_o), 64'd2);
    step();
    r_send(2'd1, 32'hA5A5_0001, 1'b1);
    r_send(2'd2, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    chk("norm_outstanding0", 64'(outstanding_o), 64'd0);
    chk("norm_irq", 64'(irq_o), 64'd0);
    step();

    // Full table
    for (int i = 0; i < 4; i++) ar_send(2'(i));
    @(negedge clk);
    chk("full_outstanding", 64'(outstanding_o), 64'd4);
    step();
    req_i.ar_valid = 1'b1;
    req_i.ar.id    = 2'd0;
    @(negedge clk);
    chk("full_ar_ready", 64'(rsp_o.ar_ready), 64'd0);
    chk("full_ar_valid_out", 64'(req_o.ar_valid), 64'd0);
    step();
    rsp_i.r_valid = 1'b1;
    rsp_i.r.id    = 2'd1;
    rsp_i.r.data  = 32'h0000_0111;
    rsp_i.r.resp  = 2'b00;
    rsp_i.r.last  = 1'b1;
    exp_q.push_back(beat(2'd1, 32'h0000_0111, 2'b00));
    @(negedge clk);
    chk("full_no_bypass", 64'(rsp_o.ar_ready), 64'd0);
    step();
    rsp_i.r_valid = 1'b0;
    @(negedge clk);
    chk("full_freed_ready", 64'(rsp_o.ar_ready), 64'd1);
    step();
    req_i.ar_valid = 1'b0;
    @(negedge clk);
    chk("full_refill", 64'(outstanding_o), 64'd4);
    step();
    r_send(2'd0, 32'h0000_0A00, 1'b1);
    r_send(2'd0, 32'h0000_0A01, 1'b1);
    r_send(2'd2, 32'h0000_0A02, 1'b1);
    r_send(2'd3, 32'h0000_0A03, 1'b1);
    @(negedge clk);
    chk("full_empty", 64'(outstanding_o), 64'd0);
    step();

    // Same-ID ordering, budget 20
    budget = 16'd20;
    ar_send(2'd3);
    t0 = cyc;
    step();
    ar_send(2'd3);
    step();
    ar_send(2'd3);
    r_send(2'd3, 32'h3333_0000, 1'b1);
    @(negedge clk);
    chk("sameid_outstanding", 64'(outstanding_o), 64'd2);
    exp_q.push_back(beat(2'd3, 32'h0, 2'b10));
    exp_q.push_back(beat(2'd3, 32'h0, 2'b10));
    check_at(t0 + 21);
    chk("sameid_oldest_freed", 64'(irq_o), 64'd0);
    check_at(t0 + 22);
    chk("sameid_irq_pre", 64'(irq_o), 64'd0);
    check_at(t0 + 23);
    chk("sameid_irq", 64'(irq_o), 64'd1);
    chk("sameid_fault_id", 64'(fault_id_o), 64'd3);
    check_at(t0 + 24);
    chk("sameid_drain_rst_req", 64'(rst_req_o), 64'd0);
    check_at(t0 + 25);
    chk("sameid_fault_rst_req", 64'(rst_req_o), 64'd1);
    chk("sameid_fault_outst", 64'(outstanding_o), 64'd0);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    @(negedge clk);
    chk("sameid_clr_irq", 64'(irq_o), 64'd0);
    chk("sameid_clr_rst_req", 64'(rst_req_o), 64'd0);
    step();

    // Timeout, budget 8
    budget = 16'd8;
    ar_send(2'd2);
    t0 = cyc;
    exp_q.push_back(beat(2'd2, 32'h0, 2'b10));
    check_at(t0 + 8);
    chk("to_irq_pre", 64'(irq_o), 64'd0);
    wait_cyc(t0 + 9);
    req_i.w_valid = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    chk("to_irq", 64'(irq_o), 64'd1);
    chk("to_fault_id", 64'(fault_id_o), 64'd2);
    chk("to_drain_ar_ready", 64'(rsp_o.ar_ready), 64'd0);
    chk("to_w_pass", 64'(req_o.w_valid), 64'd1);
    step();
    clr = 1'b0;
    req_i.w_valid = 1'b0;
    @(negedge clk);
    chk("to_fault_rst_req", 64'(rst_req_o), 64'd1);
    chk("to_fault_irq", 64'(irq_o), 64'd1);
    chk("to_fault_outst", 64'(outstanding_o), 64'd0);
    chk("to_fault_r_valid", 64'(rsp_o.r_valid), 64'd0);
    check_at(t0 + 13);
    chk("to_fault_hold", 64'(rst_req_o), 64'd1);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    @(negedge clk);
    chk("to_clr_irq", 64'(irq_o), 64'd0);
    chk("to_clr_rst_req", 64'(rst_req_o), 64'd0);
    chk("to_clr_fault_id", 64'(fault_id_o), 64'd0);
    chk("to_clr_outst", 64'(outstanding_o), 64'd0);
    step();

    // Race: R last in cycle B
    ar_send(2'd1);
    t0 = cyc;
    wait_cyc(t0 + 8);
    r_send(2'd1, 32'h0BAD_F00D, 1'b1);
    @(negedge clk);
    chk("race_irq", 64'(irq_o), 64'd0);
    chk("race_outst", 64'(outstanding_o), 64'd0);
    check_at(t0 + 12);
    chk("race_irq_late", 64'(irq_o), 64'd0);
    step();

    // Reset mid-DRAIN with three entries pending
    ar_send(2'd0);
    ar_send(2'd1);
    ar_send(2'd2);
    req_i.r_ready = 1'b0;
    n = 0;
    while (!irq_o && n < 40) begin
      step();
      n++;
    end
    @(negedge clk);
    chk("rstd_irq", 64'(irq_o), 64'd1);
    chk("rstd_pending", 64'(outstanding_o), 64'd3);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstd_irq_clr", 64'(irq_o), 64'd0);
    chk("rstd_rst_req", 64'(rst_req_o), 64'd0);
    chk("rstd_fault_id", 64'(fault_id_o), 64'd0);
    chk("rstd_outst", 64'(outstanding_o), 64'd0);
    step();
    rst_n = 1'b1;
    req_i.r_ready  = 1'b1;
    req_i.ar_valid = 1'b1;
    req_i.ar.id    = 2'd1;
    @(negedge clk);
    chk("rstd_ar_pass", 64'(req_o.ar_valid), 64'd1);
    chk("rstd_ar_ready", 64'(rsp_o.ar_ready), 64'd1);
    step();
    req_i.ar_valid = 1'b0;
    r_send(2'd1, 32'h1234_5678, 1'b1);
    @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
